mac_array_stream: RTL
=====================

// Module: mac_array_stream
// PURPOSE
//  Multi-lane streaming MAC: LANES parallel signed dot-product lanes share one b operand per beat
//  (one row of A against a broadcast column element of B). Dot-product length is set per transfer
//  by in_last, bounded by K_MAX.
//  Valid/ready handshakes on input and output; output saturation; length-error reporting.
//  Next-generation matrix-multiply datapath element; feeds a result collector/writeback stage.
// PARAMETERS
//  DATA_W  16  signed operand width (a lanes and b)
//  LANES   4   number of parallel MAC lanes
//  K_MAX   16  maximum terms per dot product (>=1)
//  OUT_W   32  signed result width per lane
//  SAT_EN  1   1: clamp result to OUT_W signed range; 0: keep low OUT_W bits (wrap)
//  localparam ACC_W  = 2*DATA_W + $clog2(K_MAX) + 1   internal accumulator width per lane
//  localparam KCNT_W = $clog2(K_MAX+1)                term-counter width
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               asynchronous, active-low reset
//  flush        in   1               synchronous abort of the in-progress dot product
//  in_valid     in   1               input beat valid
//  in_ready     out  1               input beat accepted when in_valid && in_ready
//  in_last      in   1               beat carries the final term of the dot product
//  a_in         in   LANES*DATA_W    lane l operand at [l*DATA_W +: DATA_W], signed
//  b_in         in   DATA_W          shared operand, signed
//  out_valid    out  1               result held in the output register
//  out_ready    in   1               consumer accepts result when out_valid && out_ready
//  out_data     out  LANES*OUT_W     lane l result at [l*OUT_W +: OUT_W], signed
//  out_sat      out  LANES           lane l result was clamped (always 0 when SAT_EN=0 or OUT_W>=ACC_W)
//  out_len      out  KCNT_W          number of terms in the result (1..K_MAX)
//  out_len_err  out  1               dot product ended by reaching K_MAX with no in_last
// BEHAVIOUR
//  Reset (rst_n low, async): stage-1 valid, accumulators, term count, out_valid, out_data, out_sat,
//   out_len and out_len_err all go to 0 immediately. A partial dot product is discarded.
//  Pipeline advance: adv = !out_valid || out_ready. in_ready = adv && !flush.
//   When adv=0, all stages hold.
//  Stage 1: on an accepted beat, register a_in[l]*b_in (full 2*DATA_W signed) for every lane,
//   plus last and valid.
//  Stage 2: when stage 1 is valid and adv=1, sum = acc[l] + sext(prod[l]) at ACC_W, and cnt = cnt + 1.
//   - last, or cnt+1 == K_MAX: load the output register from sum (see width rule).
//     out_len = cnt+1; out_len_err = (cnt+1 == K_MAX && !last); out_valid = 1.
//     acc = 0 and cnt = 0, so the next beat starts a new dot product.
//   - otherwise: acc = sum and cnt = cnt+1.
//  Latency: out_valid rises on the 2nd rising edge after the in_last beat is accepted.
//   With continuous out_ready=1, throughput is 1 beat/cycle, including back-to-back 1-term dot products.
//  Output register: when out_valid=1 && out_ready=0, out_data, out_sat, out_len and out_len_err stay
//   stable. out_valid falls on handshake unless a new result loads on the same edge.
//  Width rule: if OUT_W >= ACC_W, sign-extend and out_sat=0.
//   Else, with SAT_EN=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set out_sat[l] when clamped.
//   With SAT_EN=0: truncate to low OUT_W bits and out_sat=0. No overflow inside ACC_W by construction.
//  flush=1: clear stage-1 valid, acc and cnt on that edge.
//   An input beat offered that cycle is not accepted (in_ready=0).
//   The output register and its pending result are unaffected.
//  A 1-term dot product (in_last on the first beat) yields out_len=1.
//  in_last on the K_MAX-th beat gives out_len_err=0.
//  b_in and a_in are only sampled on accepted beats; there are no X-propagation requirements on idle cycles.
// TESTING
//  T1 LANES=4: b=2, a={1,2,3,4} for 3 beats, in_last on beat 3, out_ready=1
//     -> out_data={6,12,18,24}, out_len=3, out_len_err=0; out_valid 2 edges after beat 3.
//  T2 Backpressure: result pending, out_ready=0 for 5 cycles -> in_ready=0 and outputs stable;
//     after out_ready=1 the next dot product completes correctly with no beat lost or duplicated.
//  T3 OUT_W=16, SAT_EN=1: a=b=32767, 2 beats -> out_data=32767, out_sat=1;
//     a=-32768, b=32767, 2 beats -> out_data=-32768, out_sat=1; with SAT_EN=0, low 16 bits and out_sat=0.
//  T4 K_MAX=16: 17 beats with no in_last, a=1, b=1 -> first result 16, out_len=16, out_len_err=1;
//     beat 17 starts a new dot product.
//  T5 rst_n low mid-accumulation (after 2 of 4 beats) -> all outputs 0 without a clock edge;
//     after release, a fresh 4-beat dot product gives the exact sum.
//  T6 flush asserted with in_valid=1 after 2 beats -> that beat is not accepted, partial sum is discarded,
//     and a pending out_valid result is preserved; the next 1-term dot product returns out_len=1.

Source files
------------

// File: rtl/mac_array_stream.sv
// mac_array_stream: LANES parallel signed dot-product lanes sharing one b operand per beat,
// with valid/ready on both sides, per-lane saturation and a length-error flag.
module mac_array_stream #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int K_MAX  = 16,
  parameter int OUT_W  = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [LANES*DATA_W-1:0]    a_in,
  input  logic [DATA_W-1:0]          b_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*OUT_W-1:0]     out_data,
  output logic [LANES-1:0]           out_sat,
  output logic [$clog2(K_MAX+1)-1:0] out_len,
  output logic                       out_len_err
);
  localparam int ACC_W  = 2*DATA_W + $clog2(K_MAX) + 1;
  localparam int KCNT_W = $clog2(K_MAX+1);
  localparam int PROD_W = 2*DATA_W;
  logic                     adv, s1_valid, s1_last, done;
  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]  acc  [LANES];
  logic signed [ACC_W-1:0]  sum  [LANES];
  logic [KCNT_W-1:0]        cnt, cnt_nx;
  logic [LANES*OUT_W-1:0]   res;
  logic [LANES-1:0]         res_sat;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !flush;
  assign cnt_nx   = cnt + 1'b1;
  assign done     = s1_last || cnt_nx == KCNT_W'(K_MAX);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sum[l] = acc[l] + ACC_W'(prod[l]);
    if (OUT_W >= ACC_W) begin : g_ext
      assign res[l*OUT_W +: OUT_W] = OUT_W'(sum[l]);
      assign res_sat[l] = 1'b0;
    end else if (SAT_EN) begin : g_sat
      localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
      logic hi, lo;
      assign hi = sum[l] > MAXV;
      assign lo = sum[l] < MINV;
      assign res[l*OUT_W +: OUT_W] = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : sum[l][OUT_W-1:0];
      assign res_sat[l] = hi || lo;
    end else begin : g_wrap
      assign res[l*OUT_W +: OUT_W] = sum[l][OUT_W-1:0];
      assign res_sat[l] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sat     <= '0;
      out_len     <= '0;
      out_len_err <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc[i]  <= '0;
        prod[i] <= '0;
      end
    end else if (flush) begin
      // abort the partial product but leave the output register and its handshake alone
      s1_valid <= 1'b0;
      cnt      <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
      if (out_ready) out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid && done;
      if (in_valid) begin
        s1_last <= in_last;
        for (int i = 0; i < LANES; i++)
          prod[i] <= PROD_W'($signed(a_in[i*DATA_W +: DATA_W])) * PROD_W'($signed(b_in));
      end
      if (s1_valid) begin
        cnt <= done ? '0 : cnt_nx;
        for (int i = 0; i < LANES; i++) acc[i] <= done ? '0 : sum[i];
        if (done) begin
          out_data    <= res;
          out_sat     <= res_sat;
          out_len     <= cnt_nx;
          out_len_err <= !s1_last;
        end
      end
    end
  end
endmodule
